// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one of NUM_REQ byte sources own the UART TX FIFO
// for a whole message, with per-grant byte limit and stall timeout.
module uart_tx_arbiter #(
  parameter int DATA_BITS    = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BYTES    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_write_uart,
  output logic [DATA_BITS-1:0]         o_write_data,
  input  logic                         i_tx_full,
  output logic                         o_abort,
  output logic                         o_truncated
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int STL_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [CNT_W-1:0]   r_byte_cnt, w_byte_cnt_nxt, w_byte_inc;
  logic [STL_W-1:0]   r_stall_cnt, w_stall_cnt_nxt, w_stall_inc;
  logic               r_abort, w_abort_nxt;
  logic               r_truncated, w_truncated_nxt;

  logic               w_pick_found;
  logic [IDX_W-1:0]   w_pick_idx, w_cand;
  logic               w_own_valid, w_own_last, w_accept;
  logic [DATA_BITS-1:0] w_own_data;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_pick_found && i_req_valid[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end else begin
        w_pick_found = w_pick_found;
      end
    end
  end

  assign w_own_valid = i_req_valid[r_owner];
  assign w_own_last  = i_req_last[r_owner];
  assign w_own_data  = i_req_data[int'(r_owner)*DATA_BITS +: DATA_BITS];
  assign w_byte_inc  = r_byte_cnt + CNT_W'(1);
  assign w_stall_inc = r_stall_cnt + STL_W'(1);

  // Combinational datapath from the current owner to the UART FIFO.
  always_comb begin
    o_req_ready  = '0;
    o_write_uart = 1'b0;
    o_write_data = '0;
    if (r_state == ST_XFER) begin
      o_req_ready[r_owner] = ~i_tx_full;
      o_write_uart         = w_own_valid & ~i_tx_full;
      o_write_data         = w_own_data;
    end else begin
      o_write_uart = 1'b0;
    end
  end

  assign w_accept = o_write_uart;

  // Next-state logic; every release path clears the grant and records the owner.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_abort_nxt      = 1'b0;
    w_truncated_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt     = ST_XFER;
          w_owner_nxt     = w_pick_idx;
          w_grant_nxt     = NUM_REQ'(1) << w_pick_idx;
          w_byte_cnt_nxt  = '0;
          w_stall_cnt_nxt = '0;
        end else begin
          w_grant_nxt = '0;
        end
      end
      ST_XFER: begin
        if (w_accept) begin
          if (w_own_last || (w_byte_inc == CNT_W'(MAX_BYTES))) begin
            w_state_nxt      = ST_IDLE;
            w_grant_nxt      = '0;
            w_last_grant_nxt = r_owner;
            w_byte_cnt_nxt   = '0;
            w_stall_cnt_nxt  = '0;
            w_truncated_nxt  = ~w_own_last;
          end else begin
            w_byte_cnt_nxt  = w_byte_inc;
            w_stall_cnt_nxt = '0;
          end
        end else if (!w_own_valid) begin
          if (w_stall_inc == STL_W'(IDLE_TIMEOUT)) begin
            w_state_nxt      = ST_IDLE;
            w_grant_nxt      = '0;
            w_last_grant_nxt = r_owner;
            w_byte_cnt_nxt   = '0;
            w_stall_cnt_nxt  = '0;
            w_abort_nxt      = 1'b1;
          end else begin
            w_stall_cnt_nxt = w_stall_inc;
          end
        end else begin
          // FIFO back-pressure is not the requester's fault: hold the stall count.
          w_stall_cnt_nxt = r_stall_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_byte_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_abort      <= 1'b0;
      r_truncated  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_abort      <= w_abort_nxt;
      r_truncated  <= w_truncated_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_abort     = r_abort;
  assign o_truncated = r_truncated;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources are per-requester queues,
// every FIFO write, grant change and pulse is logged and compared to fixed tables.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            write_uart;
  logic [DB-1:0]   write_data;
  logic            tx_full;
  logic            abort_p;
  logic            trunc_p;

  uart_tx_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR), .MAX_BYTES(16), .IDLE_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant),
    .o_write_uart(write_uart), .o_write_data(write_data), .i_tx_full(tx_full),
    .o_abort(abort_p), .o_truncated(trunc_p)
  );

  always #5 clk = ~clk;

  logic [8:0]    srcq [NR][$];
  logic [7:0]    wq[$];
  logic [NR-1:0] wg[$];
  int            wcyc[$];
  logic [NR-1:0] gq[$];
  int            gcyc[$];
  logic [NR-1:0] prev_grant = '0;
  logic [NR-1:0] s_grant, s_ready;
  logic          s_wu, s_abort, s_trunc;
  logic [7:0]    s_wd;
  int cyc = 0, n_abort = 0, n_trunc = 0, abort_cyc = 0, trunc_cyc = 0, full_viol = 0;
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive sources, sample at the falling edge, pop accepted bytes.
  task automatic cycle();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (srcq[i].size() > 0);
      req_data[i*DB +: DB] = req_valid[i] ? srcq[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? srcq[i][0][8] : 1'b0;
    end
    @(negedge clk);
    s_grant = grant; s_ready = req_ready; s_wu = write_uart; s_wd = write_data;
    s_abort = abort_p; s_trunc = trunc_p;
    if (write_uart) begin
      wq.push_back(write_data); wg.push_back(grant); wcyc.push_back(cyc);
      if (tx_full) full_viol++;
    end
    if (abort_p) begin n_abort++; abort_cyc = cyc; end
    if (trunc_p) begin n_trunc++; trunc_cyc = cyc; end
    if (grant !== prev_grant) begin
      gq.push_back(grant); gcyc.push_back(cyc); prev_grant = grant;
    end
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    do begin cycle(); n++; end while (!(all_empty() && s_grant == '0) && n < budget);
    check({tag, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int b, gb, ab, tb0, k;
    logic [7:0] exp5 [8];
    exp5 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h58, 8'h59, 8'h5A, 8'h5B};
    rst = 1'b1; tx_full = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    @(posedge clk); #1;

    // Reset state with requests already pending (req0 / req2 two-byte messages).
    srcq[0].push_back({1'b0, 8'h10}); srcq[0].push_back({1'b1, 8'h11});
    srcq[2].push_back({1'b0, 8'h20}); srcq[2].push_back({1'b1, 8'h21});
    cycle();
    check("rst_grant", 32'(s_grant), 32'h0);
    check("rst_ready", 32'(s_ready), 32'h0);
    check("rst_wu", 32'(s_wu), 32'h0);
    check("rst_wd", 32'(s_wd), 32'h0);
    check("rst_pulses", 32'({s_abort, s_trunc}), 32'h0);

    // Two interleaved requesters: 0 first, then 2, idle gap between.
    rst = 1'b0; b = wq.size(); gb = gq.size();
    drain("rr02", 40);
    check("rr02_cnt", 32'(wq.size() - b), 32'd4);
    for (k = 0; k < 4; k++)
      check("rr02_data", 32'(wq[b+k]), 32'(k < 2 ? 8'h10 + 8'(k) : 8'h20 + 8'(k - 2)));
    check("rr02_g0", 32'(gq[gb]), 32'h1);
    check("rr02_gap", 32'(gq[gb+1]), 32'h0);
    check("rr02_g1", 32'(gq[gb+2]), 32'h4);

    // Requester 1 with five cycles of FIFO full after its first byte.
    b = wq.size(); ab = n_abort;
    srcq[1].push_back({1'b0, 8'hA1}); srcq[1].push_back({1'b0, 8'hA2});
    srcq[1].push_back({1'b1, 8'hA3});
    k = 0;
    while (wq.size() == b && k < 10) begin cycle(); k++; end
    tx_full = 1'b1;
    repeat (5) cycle();
    check("full_nowr", 32'(wq.size() - b), 32'd1);
    tx_full = 1'b0;
    drain("full", 40);
    check("full_cnt", 32'(wq.size() - b), 32'd3);
    for (k = 0; k < 3; k++) check("full_data", 32'(wq[b+k]), 32'(8'hA1 + 8'(k)));
    check("full_viol", 32'(full_viol), 32'd0);
    check("full_abort", 32'(n_abort - ab), 32'd0);

    // Requester 3 sends one byte then goes quiet; waiting requester 0 follows.
    b = wq.size(); gb = gq.size(); ab = n_abort;
    srcq[3].push_back({1'b0, 8'h33}); srcq[0].push_back({1'b1, 8'h40});
    drain("tmo", 200);
    check("tmo_abort_n", 32'(n_abort - ab), 32'd1);
    check("tmo_d0", 32'(wq[b]), 32'h33);
    check("tmo_g0", 32'(wg[b]), 32'h8);
    check("tmo_when", 32'(abort_cyc - wcyc[b]), 32'd65);
    check("tmo_clr", 32'(gq[gb+1]), 32'h0);
    check("tmo_clr_t", 32'(gcyc[gb+1]), 32'(abort_cyc));
    check("tmo_next_g", 32'(gq[gb+2]), 32'h1);
    check("tmo_next_t", 32'(gcyc[gb+2] - abort_cyc), 32'd1);
    check("tmo_d1", 32'(wq[b+1]), 32'h40);

    // Requester 2 streams without last; remaining bytes withdrawn after the 16th write.
    b = wq.size(); tb0 = n_trunc; ab = n_abort;
    for (k = 0; k < 20; k++) srcq[2].push_back({1'b0, 8'h80 + 8'(k)});
    k = 0;
    while (wq.size() - b < 16 && k < 60) begin cycle(); k++; end
    srcq[2].delete();
    repeat (4) cycle();
    check("trn_cnt", 32'(wq.size() - b), 32'd16);
    check("trn_first", 32'(wq[b]), 32'h80);
    check("trn_last", 32'(wq[b+15]), 32'h8F);
    check("trn_owner", 32'(wg[b+15]), 32'h4);
    check("trn_pulse", 32'(n_trunc - tb0), 32'd1);
    check("trn_when", 32'(trunc_cyc - wcyc[b+15]), 32'd1);
    check("trn_rel", 32'(s_grant), 32'h0);
    check("trn_abort", 32'(n_abort - ab), 32'd0);

    // Fresh reset, all four continuously valid with single-byte messages.
    rst = 1'b1; cycle(); rst = 1'b0;
    b = wq.size(); gb = gq.size();
    for (int i = 0; i < NR; i++) begin
      srcq[i].push_back({1'b1, 8'h50 + 8'(i)});
      srcq[i].push_back({1'b1, 8'h58 + 8'(i)});
    end
    drain("rr4", 80);
    check("rr4_cnt", 32'(wq.size() - b), 32'd8);
    for (k = 0; k < 8; k++) begin
      check("rr4_data", 32'(wq[b+k]), 32'(exp5[k]));
      check("rr4_grant", 32'(wg[b+k]), 32'(4'b0001 << (k % 4)));
    end
    check("rr4_grants", 32'(gq.size() - gb), 32'd16);

    // Reset in the middle of a 4-byte message from requester 1.
    b = wq.size();
    for (k = 0; k < 4; k++) srcq[1].push_back({(k == 3) ? 1'b1 : 1'b0, 8'hC1 + 8'(k)});
    k = 0;
    while (wq.size() - b < 2 && k < 10) begin cycle(); k++; end
    rst = 1'b1;
    cycle();
    check("mrst_grant", 32'(s_grant), 32'h0);
    check("mrst_wu", 32'(s_wu), 32'h0);
    check("mrst_ready", 32'(s_ready), 32'h0);
    check("mrst_wd", 32'(s_wd), 32'h0);
    cycle();
    check("mrst_nowr", 32'(wq.size() - b), 32'd2);
    srcq[0].push_back({1'b1, 8'hD0});
    rst = 1'b0;
    drain("mrst", 40);
    check("mrst_cnt", 32'(wq.size() - b), 32'd5);
    check("mrst_first", 32'(wg[b+2]), 32'h1);
    check("mrst_d0", 32'(wq[b+2]), 32'hD0);
    check("mrst_c3", 32'(wq[b+3]), 32'hC3);
    check("mrst_c4", 32'(wq[b+4]), 32'hC4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
